// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the unified memory port arbiter.
// Also imported by the CPU for its default memory geometry.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    localparam int REQ_CPU = 0;
    localparam int REQ_EXT = 1;

    typedef enum logic [1:0] {
        OPEN,
        LOCK_CPU,
        LOCK_EXT
    } lock_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; the pointer flips to the loser
// only when both requesters were contending.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] pick
);

    // ptr_q = 0 favours req[0], 1 favours req[1]
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        pick  = 2'b00;
        ptr_d = ptr_q;
        if (enable) begin
            if (req == 2'b11) begin
                pick = ptr_q ? 2'b10 : 2'b01;
            end else begin
                pick = req;
            end
            if (advance && req == 2'b11) begin
                ptr_d = pick[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port 16x8 memory shared by the CPU and an external loader,
// with per-cycle round-robin arbitration and an ownership lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              busy_lock
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    lock_state_e       state_q, state_d;
    logic              busy_lock_q, busy_lock_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic [1:0]        pick;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    rr_pick2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({ext_req, cpu_req}),
        .enable  (state_q == OPEN),
        .advance (cpu_req & ext_req),
        .pick    (pick)
    );

    // Grants are gated by rst_n so nothing is accepted while in reset
    always_comb begin
        cpu_gnt = rst_n & (pick[REQ_CPU] |
                  ((state_q == LOCK_CPU) & cpu_req));
        ext_gnt = rst_n & (pick[REQ_EXT] |
                  ((state_q == LOCK_EXT) & ext_req));

        state_d = state_q;
        unique case (state_q)
            OPEN: begin
                if (cpu_gnt && cpu_lock) begin
                    state_d = LOCK_CPU;
                end else if (ext_gnt && ext_lock) begin
                    state_d = LOCK_EXT;
                end
            end
            LOCK_CPU: if (cpu_gnt && !cpu_lock) state_d = OPEN;
            LOCK_EXT: if (ext_gnt && !ext_lock) state_d = OPEN;
            default:  state_d = OPEN;
        endcase
        busy_lock_d = (state_d != OPEN);

        wr_en   = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
        wr_addr = cpu_gnt ? cpu_addr : ext_addr;
        wr_data = cpu_gnt ? cpu_wdata : ext_wdata;

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        ext_rvalid_d = ext_gnt & ~ext_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_q[cpu_addr] : cpu_rdata_q;
        ext_rdata_d  = ext_rvalid_d ? mem_q[ext_addr] : ext_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OPEN;
            busy_lock_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_lock_q  <= busy_lock_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign busy_lock  = busy_lock_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ext_rvalid = ext_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, reset-in-lock sequence,
// and random traffic against an owner/favourite reference model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       c_req, c_we, c_lock;
    logic [3:0] c_addr;
    logic [7:0] c_wdata;
    logic       e_req, e_we, e_lock;
    logic [3:0] e_addr;
    logic [7:0] e_wdata;
    logic       cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, busy_lock;
    logic [7:0] cpu_rdata, ext_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (c_req),
        .cpu_we     (c_we),
        .cpu_lock   (c_lock),
        .cpu_addr   (c_addr),
        .cpu_wdata  (c_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (e_req),
        .ext_we     (e_we),
        .ext_lock   (e_lock),
        .ext_addr   (e_addr),
        .ext_wdata  (e_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .busy_lock  (busy_lock)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: owner -1 none / 0 cpu / 1 ext, fav = favoured requester
    int m_mem [16];
    int m_owner, m_fav, m_crd, m_erd, m_crv, m_erv;
    int s_cgnt, s_egnt, s_crv, s_erv;

    typedef struct {
        bit cr, cw, cl; int ca, cd;
        bit er, ew, el; int ea, ed;
        bit x_cg, x_eg, x_crv, x_erv, x_busy; int x_rd;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_fav = 0;
        m_crd = 0; m_erd = 0; m_crv = 0; m_erv = 0;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_lock = 0; c_addr = 0; c_wdata = 0;
        e_req = 0; e_we = 0; e_lock = 0; e_addr = 0; e_wdata = 0;
    endtask

    // one clock cycle; entered and left just after a negedge
    task automatic do_cycle();
        int gc, ge;
        #2;
        chk("busy_pre", busy_lock, m_owner != -1);
        if (m_owner == 0) begin
            gc = c_req; ge = 0;
        end else if (m_owner == 1) begin
            gc = 0; ge = e_req;
        end else if (c_req && e_req) begin
            gc = (m_fav == 0); ge = !gc; m_fav = gc ? 1 : 0;
        end else begin
            gc = c_req; ge = e_req;
        end
        chk("cpu_gnt", cpu_gnt, gc);
        chk("ext_gnt", ext_gnt, ge);
        s_cgnt = cpu_gnt; s_egnt = ext_gnt;
        m_crv = 0; m_erv = 0;
        if (gc != 0) begin
            if (c_we) m_mem[c_addr] = c_wdata;
            else begin m_crv = 1; m_crd = m_mem[c_addr]; end
            m_owner = c_lock ? 0 : -1;
        end
        if (ge != 0) begin
            if (e_we) m_mem[e_addr] = e_wdata;
            else begin m_erv = 1; m_erd = m_mem[e_addr]; end
            m_owner = e_lock ? 1 : -1;
        end
        @(posedge clk); #1;
        chk("cpu_rvalid", cpu_rvalid, m_crv);
        chk("ext_rvalid", ext_rvalid, m_erv);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("ext_rdata", ext_rdata, m_erd);
        chk("busy_post", busy_lock, m_owner != -1);
        s_crv = cpu_rvalid; s_erv = ext_rvalid;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 0;
        idle_inputs();
        c_req = 1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_busy", busy_lock, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        c_req = 0;
        m_reset();
    endtask

    task automatic apply(input vec_t v);
        c_req = v.cr; c_we = v.cw; c_lock = v.cl;
        c_addr = 4'(v.ca); c_wdata = 8'(v.cd);
        e_req = v.er; e_we = v.ew; e_lock = v.el;
        e_addr = 4'(v.ea); e_wdata = 8'(v.ed);
    endtask

    initial begin
        idle_inputs();
        m_reset();
        reset_dut();

        // preload every word with A0+i
        for (int i = 0; i < 16; i++) begin
            c_req = 1; c_we = 1; c_addr = 4'(i); c_wdata = 8'(8'hA0 + i);
            do_cycle();
        end
        idle_inputs();
        reset_dut();

        vt.push_back('{0,0,0,0,0,     1,1,0,3,'h11, 0,1,0,0,0,0});
        vt.push_back('{1,0,0,3,0,     0,0,0,0,0,    1,0,1,0,0,'h11});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    1,0,1,0,0,'hA0});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    0,1,0,1,0,'hA1});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    1,0,1,0,0,'hA0});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    0,1,0,1,0,'hA1});
        vt.push_back('{1,0,1,5,0,     1,0,0,5,0,    1,0,1,0,1,'hA5});
        vt.push_back('{1,1,0,5,'hFA,  1,0,0,5,0,    1,0,0,0,0,0});
        vt.push_back('{1,0,0,0,0,     1,0,0,5,0,    0,1,0,1,0,'hFA});
        vt.push_back('{1,0,0,0,0,     0,0,0,0,0,    1,0,1,0,0,'hA0});
        vt.push_back('{1,1,0,15,'h7E, 0,0,0,0,0,    1,0,0,0,0,0});
        vt.push_back('{1,0,0,15,0,    0,0,0,0,0,    1,0,1,0,0,'h7E});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    1,0,1,0,0,'hA0});
        vt.push_back('{0,0,0,0,0,     0,0,0,0,0,    0,0,0,0,0,0});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    0,1,0,1,0,'hA1});
        vt.push_back('{0,0,0,0,0,     0,0,0,0,0,    0,0,0,0,0,0});
        vt.push_back('{0,0,0,0,0,     0,0,0,0,0,    0,0,0,0,0,0});
        vt.push_back('{1,0,0,0,0,     1,0,0,1,0,    1,0,1,0,0,'hA0});

        foreach (vt[i]) begin
            apply(vt[i]);
            do_cycle();
            chk($sformatf("v%0d_cgnt", i), s_cgnt, vt[i].x_cg);
            chk($sformatf("v%0d_egnt", i), s_egnt, vt[i].x_eg);
            chk($sformatf("v%0d_crv", i), s_crv, vt[i].x_crv);
            chk($sformatf("v%0d_erv", i), s_erv, vt[i].x_erv);
            chk($sformatf("v%0d_busy", i), busy_lock, vt[i].x_busy);
            if (vt[i].x_crv) chk($sformatf("v%0d_crd", i), cpu_rdata, vt[i].x_rd);
            if (vt[i].x_erv) chk($sformatf("v%0d_erd", i), ext_rdata, vt[i].x_rd);
        end

        // reset while ext holds the lock and a read is being granted
        idle_inputs();
        e_req = 1; e_lock = 1; e_addr = 4;
        do_cycle();
        e_addr = 6;
        c_req = 1; c_we = 1; c_addr = 2; c_wdata = 8'h55;
        #2;
        chk("lk_ext_gnt", ext_gnt, 1);
        rst_n = 0;
        #1;
        chk("lk_rst_erv", ext_rvalid, 0);
        chk("lk_rst_busy", busy_lock, 0);
        chk("lk_rst_egnt", ext_gnt, 0);
        chk("lk_rst_cgnt", cpu_gnt, 0);
        @(posedge clk); #1;
        chk("lk_rst_erv2", ext_rvalid, 0);
        @(negedge clk);
        rst_n = 1;
        m_reset();
        idle_inputs();
        c_req = 1; c_addr = 15; e_req = 1; e_addr = 5;
        do_cycle();
        chk("lk_first_cpu", s_cgnt, 1);
        chk("lk_m15", cpu_rdata, 'h7E);
        c_addr = 2;
        do_cycle();
        do_cycle();
        chk("lk_m2_kept", cpu_rdata, 'hA2);
        c_req = 0;
        do_cycle();
        chk("lk_m5", ext_rdata, 'hFA);

        // random traffic
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            if (!c_req && $urandom_range(2) != 0) begin
                c_req = 1; c_we = 1'($urandom);
                c_lock = ($urandom_range(3) == 0);
                c_addr = 4'($urandom); c_wdata = 8'($urandom);
            end
            if (!e_req && $urandom_range(2) != 0) begin
                e_req = 1; e_we = 1'($urandom);
                e_lock = ($urandom_range(3) == 0);
                e_addr = 4'($urandom); e_wdata = 8'($urandom);
            end
            do_cycle();
            if (s_cgnt != 0) c_req = 0;
            if (s_egnt != 0) e_req = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Owns the 16 x 8 unified instruction/data memory. Shares its single port between the CPU core (fetch, indirect-address read, operand read/write) and an external loader/debug port.
- Arbitration is per cycle and round-robin.
- A lock lets either requester make read-modify-write sequences atomic (the CPU uses this for the double and complement instructions).
- Sits between the CPU sequencer and the memory array; it replaces direct array indexing by the core.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory word width
DEPTH, 16, number of words (must equal 2**ADDR_W)

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_lock  in  1  keep ownership after this access
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid (1 cycle after read grant)
cpu_rdata  out  DATA_W  CPU read data
ext_req, ext_we, ext_lock, ext_addr, ext_wdata  in  1/1/1/ADDR_W/DATA_W  external port, same meaning as cpu_*
ext_gnt, ext_rvalid  out  1  external grant / read valid
ext_rdata  out  DATA_W  external read data
busy_lock  out  1  a lock is currently held by either requester

Behaviour:
- Reset (rst_n low, asynchronous): gnts, rvalids and busy_lock = 0; rdata outputs = 0; lock state = OPEN; round-robin pointer = CPU-first. The memory array is not reset (contents persist).
- At most one gnt per cycle.
- A granted access is performed at the posedge ending the grant cycle:
  - write: mem[addr] <= wdata
  - read: requester's rdata <= mem[addr], rvalid <= 1 for exactly one cycle.
- Read latency: 1 cycle. A read issued the cycle after a write to the same address returns the new data.
- rvalid is 0 in all cycles that do not follow a read grant. rdata holds its last value when rvalid is 0.
- Requests are level; a requester keeps req/we/addr/wdata/lock stable until gnt. Back-to-back accesses are allowed (req held high, new fields presented the cycle after gnt).
- Lock state machine:
  - OPEN: arbitrate.
    - Only one req high -> grant it.
    - Both high -> grant the pointer's favourite; the pointer then favours the other requester.
    - If the granted access has lock = 1 -> LOCK_CPU or LOCK_EXT.
  - LOCK_CPU: only the CPU may be granted (whenever cpu_req = 1); ext_gnt = 0. A CPU grant with cpu_lock = 0 -> OPEN at that edge.
  - LOCK_EXT: symmetric to LOCK_CPU.
  - busy_lock = 1 in LOCK_CPU and LOCK_EXT.
- The pointer only advances on contended grants in OPEN. Locked grants do not move it.
- Fairness: in OPEN with both requesters continuously requesting, grants alternate CPU, EXT, CPU, ...
- Reset mid-operation:
  - A pending read's rvalid is dropped.
  - A write is committed only if the posedge occurs with rst_n high.
  - The lock is released.

Decomposition:
- Package mem_arb_pkg:
  - lock-state enum {OPEN, LOCK_CPU, LOCK_EXT}
  - requester id constants REQ_CPU = 0, REQ_EXT = 1
  - default ADDR_W/DATA_W/DEPTH constants shared with the CPU
- One sub-module, rr_pick2: 2-way round-robin picker holding the pointer flop. Inputs: req[1:0], enable, advance. Output: one-hot pick.
- The lock FSM, the memory array and the read-data registers stay in mem_port_arbiter.

Test Plan:
- Reset then ext writes 0x11 to addr 3, then CPU reads addr 3 -> cpu_gnt in cycle 1; one cycle later cpu_rvalid = 1, cpu_rdata = 0x11; ext_rvalid stays 0.
- Both requesters hold req (reads of addr 0 and 1) for 4 cycles after reset -> grants CPU, EXT, CPU, EXT, with exactly one gnt per cycle.
- CPU read of addr 5 with lock = 1, ext_req held high, then CPU write 0xFA to addr 5 with lock = 0 -> ext_gnt = 0 and busy_lock = 1 throughout; ext is granted the cycle after the unlocking write; an ext read of addr 5 returns 0xFA.
- Write 0x7E to addr 15 followed immediately by a read of addr 15 -> rdata = 0x7E (read-after-write, top address).
- Assert rst_n low while in LOCK_EXT with a read just granted -> ext_rvalid = 0, busy_lock = 0 immediately; after release, the CPU wins the first contended cycle; memory contents written before reset are intact.
- Idle cycles (no req) -> no gnt, no rvalid, pointer unchanged; the next contended cycle goes to the previously favoured requester.
